prim_pad_filter_bank: RTL and testbench

Multi-channel, clocked successor to the generic pad wrapper. It holds a WARL-masked attribute register per pad and registers the output path, with inversion and virtual open-drain applied. The input path per pad is a synchroniser, inversion, a programmable glitch filter and edge detection. It sits between the pinmux/IO registers and the technology pad cells; the cells only see pad_out_o/pad_oe_o and return raw pad_in_i.

---
 rtl/prim_pad_bank_pkg.sv | 21 ++
 rtl/prim_pad_glitch_filter.sv | 60 ++++++
 rtl/prim_pad_filter_bank.sv | 79 +++++++
 tb/tb_prim_pad_filter_bank.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/prim_pad_bank_pkg.sv
// Shared constants and types for the pad filter bank.
// Attribute layout: inv, od, pull enable/select, keeper, drive strength.
package prim_pad_bank_pkg;

  localparam int AttrInv    = 0;
  localparam int AttrOd     = 1;
  localparam int AttrPe     = 2;
  localparam int AttrPs     = 3;
  localparam int AttrKp     = 4;
  localparam int AttrDrvLsb = 7;

  typedef enum logic [1:0] {
    DrvLow  = 2'd0,
    DrvMed  = 2'd1,
    DrvHigh = 2'd2,
    DrvMax  = 2'd3
  } drv_e;

  localparam logic [9:0] DefaultWarlMask = 10'h19F;

endpackage

// File: rtl/prim_pad_glitch_filter.sv
// One input channel: 2-flop sync, inversion, glitch filter and
// registered edge pulses on the filtered level.
module prim_pad_glitch_filter #(
  parameter int FilterCntW = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pad_in_i,
  input  logic                  inv_i,
  input  logic                  ie_i,
  input  logic [FilterCntW-1:0] thresh_i,
  output logic                  in_o,
  output logic                  rise_o,
  output logic                  fall_o
);

  logic [1:0]            sync_q;
  logic                  st_q;
  logic [FilterCntW-1:0] cnt_q;
  logic                  s;
  logic [FilterCntW:0]   cnt_inc;

  assign s       = sync_q[1] ^ inv_i;
  assign cnt_inc = {1'b0, cnt_q} + (FilterCntW+1)'(1);
  assign in_o    = st_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      st_q   <= 1'b0;
      cnt_q  <= '0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pad_in_i};
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (!ie_i) begin
        st_q  <= 1'b0;
        cnt_q <= '0;
      end else if (thresh_i == '0) begin
        st_q   <= s;
        cnt_q  <= '0;
        rise_o <= s & ~st_q;
        fall_o <= ~s & st_q;
      end else if (s == st_q) begin
        cnt_q <= '0;
      end else if (cnt_inc >= {1'b0, thresh_i}) begin
        // pulse registered on the same edge the stable level flips
        st_q   <= s;
        cnt_q  <= '0;
        rise_o <= s;
        fall_o <= ~s;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + FilterCntW'(1);
      end
    end
  end

endmodule

// File: rtl/prim_pad_filter_bank.sv
// Multi-pad wrapper: WARL attribute registers, registered output
// path with inversion / virtual open-drain, filtered input path.
module prim_pad_filter_bank
  import prim_pad_bank_pkg::*;
#(
  parameter int                NumPads    = 8,
  parameter int                AttrDw     = 10,
  parameter int                FilterCntW = 4,
  parameter logic [AttrDw-1:0] WarlMask   = AttrDw'(DefaultWarlMask)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumPads-1:0]        attr_we_i,
  input  logic [AttrDw-1:0]         attr_wdata_i,
  output logic [NumPads*AttrDw-1:0] attr_o,
  output logic [AttrDw-1:0]         warl_o,
  input  logic [NumPads-1:0]        out_i,
  input  logic [NumPads-1:0]        oe_i,
  input  logic [NumPads-1:0]        ie_i,
  input  logic [FilterCntW-1:0]     filt_thresh_i,
  output logic [NumPads-1:0]        pad_out_o,
  output logic [NumPads-1:0]        pad_oe_o,
  input  logic [NumPads-1:0]        pad_in_i,
  output logic [NumPads-1:0]        in_o,
  output logic [NumPads-1:0]        rise_o,
  output logic [NumPads-1:0]        fall_o
);

  logic [AttrDw-1:0]  attr_q [NumPads];
  logic [NumPads-1:0] inv;
  logic [NumPads-1:0] od;
  logic [NumPads-1:0] o;

  assign warl_o = WarlMask;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumPads; k++) attr_q[k] <= '0;
    end else begin
      for (int k = 0; k < NumPads; k++) begin
        if (attr_we_i[k]) attr_q[k] <= attr_wdata_i & WarlMask;
      end
    end
  end

  for (genvar k = 0; k < NumPads; k++) begin : g_pad
    assign attr_o[k*AttrDw +: AttrDw] = attr_q[k];
    assign inv[k] = attr_q[k][AttrInv];
    assign od[k]  = attr_q[k][AttrOd];

    prim_pad_glitch_filter #(
      .FilterCntW(FilterCntW)
    ) u_filt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pad_in_i(pad_in_i[k]),
      .inv_i   (inv[k]),
      .ie_i    (ie_i[k]),
      .thresh_i(filt_thresh_i),
      .in_o    (in_o[k]),
      .rise_o  (rise_o[k]),
      .fall_o  (fall_o[k])
    );
  end

  assign o = out_i ^ inv;

  // open-drain pads only ever drive a 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pad_out_o <= '0;
      pad_oe_o  <= '0;
    end else begin
      pad_out_o <= o;
      pad_oe_o  <= oe_i & (~od | ~o);
    end
  end

endmodule

// File: tb/tb_prim_pad_filter_bank.sv
// Randomised bench for prim_pad_filter_bank against a
// cycle-level reference model plus directed corner cases.
module tb_prim_pad_filter_bank;

  localparam int NP = 8;
  localparam int AW = 10;
  localparam int CW = 4;
  localparam logic [AW-1:0] MASK = 10'h19F;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP-1:0]    attr_we = '0;
  logic [AW-1:0]    attr_wdata = '0;
  logic [NP*AW-1:0] attr_o;
  logic [AW-1:0]    warl_o;
  logic [NP-1:0]    out_i = '0, oe_i = '0, ie_i = '0;
  logic [CW-1:0]    thresh = '0;
  logic [NP-1:0]    pad_out, pad_oe, pad_in = '0;
  logic [NP-1:0]    in_o, rise_o, fall_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [AW-1:0] m_attr [NP];
  logic [NP-1:0] m_raw1, m_raw2, m_st, m_rise, m_fall;
  logic [NP-1:0] m_pout, m_poe;
  int            m_run [NP];

  prim_pad_filter_bank dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .attr_we_i    (attr_we),
    .attr_wdata_i (attr_wdata),
    .attr_o       (attr_o),
    .warl_o       (warl_o),
    .out_i        (out_i),
    .oe_i         (oe_i),
    .ie_i         (ie_i),
    .filt_thresh_i(thresh),
    .pad_out_o    (pad_out),
    .pad_oe_o     (pad_oe),
    .pad_in_i     (pad_in),
    .in_o         (in_o),
    .rise_o       (rise_o),
    .fall_o       (fall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NP*AW-1:0] m_attr_flat();
    logic [NP*AW-1:0] r;
    for (int k = 0; k < NP; k++) r[k*AW +: AW] = m_attr[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NP; k++) begin
      m_attr[k] = '0;
      m_run[k]  = 0;
    end
    m_raw1 = '0; m_raw2 = '0; m_st = '0;
    m_rise = '0; m_fall = '0; m_pout = '0; m_poe = '0;
  endtask

  // advance model by one clock using the inputs currently applied
  task automatic model_edge();
    logic [AW-1:0] na [NP];
    logic [NP-1:0] nst, nr, nf, npo, npe;
    int            nrun [NP];
    for (int k = 0; k < NP; k++) begin
      logic inv, od, s, o;
      inv = m_attr[k][0];
      od  = m_attr[k][1];
      o   = out_i[k] ^ inv;
      npo[k] = o;
      npe[k] = oe_i[k] && (!od || !o);
      na[k]  = attr_we[k] ? (attr_wdata & MASK) : m_attr[k];
      s = m_raw2[k] ^ inv;
      nst[k] = m_st[k]; nr[k] = 1'b0; nf[k] = 1'b0;
      nrun[k] = m_run[k];
      if (!ie_i[k]) begin
        nst[k] = 1'b0; nrun[k] = 0;
      end else if (s == m_st[k]) begin
        nrun[k] = 0;
      end else if (m_run[k] + 1 >= int'(thresh)) begin
        nst[k] = s; nrun[k] = 0; nr[k] = s; nf[k] = !s;
      end else begin
        nrun[k] = m_run[k] + 1;
      end
    end
    m_raw2 = m_raw1; m_raw1 = pad_in;
    for (int k = 0; k < NP; k++) begin
      m_attr[k] = na[k];
      m_run[k]  = nrun[k];
    end
    m_st = nst; m_rise = nr; m_fall = nf; m_pout = npo; m_poe = npe;
  endtask

  task automatic compare_all();
    check("attr", attr_o, m_attr_flat());
    check("pad_out", pad_out, m_pout);
    check("pad_oe", pad_oe, m_poe);
    check("in", in_o, m_st);
    check("rise", rise_o, m_rise);
    check("fall", fall_o, m_fall);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int n;
    bit seen;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_attr", attr_o, '0);
    check("rst_outs", {pad_out, pad_oe, in_o, rise_o, fall_o}, '0);
    check("warl", warl_o, 10'h19F);
    rst = 1'b0;
    ie_i = '1;

    // WARL masking
    attr_we = 8'h01; attr_wdata = 10'h3FF;
    step();
    check("warl_write", attr_o[AW-1:0], 10'h19F);
    attr_we = 8'h01; attr_wdata = '0;
    step();
    attr_we = '0;

    // latency with thresh=3
    thresh = 4'd3;
    repeat (6) step();
    pad_in[2] = 1'b1;
    n = 0;
    while (!in_o[2] && n < 20) begin
      step();
      n++;
    end
    check("lat3", n, 5);
    check("lat3_rise", rise_o[2], 1'b1);

    // 2-cycle glitch is rejected
    seen = 1'b0;
    pad_in[1] = 1'b1;
    repeat (2) step();
    pad_in[1] = 1'b0;
    repeat (8) begin
      step();
      seen |= in_o[1] | rise_o[1] | fall_o[1];
    end
    check("glitch", seen, 1'b0);

    // open-drain, then open-drain + inversion
    attr_we = 8'h01; attr_wdata = 10'h002;
    oe_i[0] = 1'b1; out_i[0] = 1'b0;
    step();
    attr_we = '0;
    step();
    check("od_lo", pad_oe[0], 1'b1);
    out_i[0] = 1'b1;
    step();
    check("od_hi", pad_oe[0], 1'b0);
    attr_we = 8'h01; attr_wdata = 10'h003;
    step();
    attr_we = '0;
    step();
    check("odinv_hi", pad_oe[0], 1'b1);
    out_i[0] = 1'b0;
    step();
    check("odinv_lo", pad_oe[0], 1'b0);

    // ie gating with bypass filter
    thresh = '0;
    pad_in[3] = 1'b1;
    repeat (4) step();
    ie_i[3] = 1'b0;
    step();
    check("ie_off", {in_o[3], fall_o[3]}, 2'b00);
    ie_i[3] = 1'b1;
    step();
    check("ie_on", {in_o[3], rise_o[3]}, 2'b11);

    // randomised traffic
    for (int c = 0; c < 1500; c++) begin
      attr_we = ($urandom_range(0, 7) == 0) ? NP'($urandom) : '0;
      attr_wdata = AW'($urandom);
      out_i = NP'($urandom);
      oe_i = NP'($urandom);
      for (int k = 0; k < NP; k++) begin
        if ($urandom_range(0, 4) == 0) pad_in[k] = ~pad_in[k];
        ie_i[k] = ($urandom_range(0, 15) != 0);
      end
      if ($urandom_range(0, 49) == 0) thresh = CW'($urandom_range(0, 5));
      step();
    end

    // async reset mid-count with outputs high
    thresh = 4'd3;
    attr_we = '0;
    out_i = '1; oe_i = '1; ie_i = '1; pad_in = '1;
    repeat (6) step();
    pad_in = '0;
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    check("async_rst", {pad_out, pad_oe, in_o, rise_o, fall_o}, '0);
    check("async_attr", attr_o, '0);
    model_reset();
    #2 rst = 1'b0;
    pad_in = '1;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
